// File: rtl/sparse_index_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sparse_index_queue                                           |
// | Description : Scans one frame of NUM_INPUTS pixels under a valid/ready     |
// |               handshake and queues the index of every pixel whose value   |
// |               is >= THRESHOLD in a circular FIFO. The FIFO feeds the layer |
// |               controller through a first-word-fall-through valid/ready    |
// |               port. Frame progress is reported via scan_done/frame_done.  |
// | Option      : define SPARSE_QUEUE_VALUE_OUT_EN to also queue each active   |
// |               pixel's value and present it on out_value.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sparse_index_queue #(
  parameter int NUM_INPUTS  = 784,
  parameter int INDEX_WIDTH = 10,
  parameter int QUEUE_DEPTH = 16,
  parameter int PIXEL_WIDTH = 8,
  parameter int THRESHOLD   = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic                             pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]           pixel_value,
  output logic                             pixel_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [INDEX_WIDTH-1:0]           out_index,
`ifdef SPARSE_QUEUE_VALUE_OUT_EN
  output logic [PIXEL_WIDTH-1:0]           out_value,
`endif
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic [INDEX_WIDTH:0]             active_count,
  output logic                             scan_done,
  output logic                             frame_done
);

  // Pointer width covers slots 0..QUEUE_DEPTH-1; occupancy width covers 0..QUEUE_DEPTH.
  localparam int C_PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int C_CNT_W = $clog2(QUEUE_DEPTH + 1);

  // Typed copies of the numeric parameters so every compare is width-matched.
  localparam logic [C_CNT_W-1:0]     C_DEPTH      = C_CNT_W'(QUEUE_DEPTH);
  localparam logic [C_PTR_W-1:0]     C_LAST_PTR   = C_PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [INDEX_WIDTH-1:0] C_LAST_PIXEL = INDEX_WIDTH'(NUM_INPUTS - 1);
  localparam logic [PIXEL_WIDTH-1:0] C_THRESHOLD  = PIXEL_WIDTH'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic                     w_pixelReady;

  // Frame scan bookkeeping
  logic [INDEX_WIDTH-1:0]   r_pixelCount;
  logic [INDEX_WIDTH:0]     r_activeCount;
  logic                     r_scanDone;
  logic                     r_frameDone;

  // Circular FIFO
  logic [INDEX_WIDTH-1:0]   r_indexMem [QUEUE_DEPTH];
  logic [C_PTR_W-1:0]       r_wrPtr;
  logic [C_PTR_W-1:0]       r_rdPtr;
  logic [C_CNT_W-1:0]       r_count;
  logic [INDEX_WIDTH-1:0]   r_lastIndex;

  // Handshake decodes
  logic                     w_accept;
  logic                     w_active;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_lastPixel;
  logic                     w_startFrame;
  logic                     w_queueEmpty;

  // Advance a FIFO pointer, wrapping at the last slot (depth need not be a power of two).
  function automatic logic [C_PTR_W-1:0] f_nextPtr(input logic [C_PTR_W-1:0] ptr);
    return (ptr == C_LAST_PTR) ? '0 : ptr + C_PTR_W'(1);
  endfunction

  assign w_queueEmpty = (r_count == '0);
  assign w_accept     = pixel_valid & w_pixelReady;
  assign w_active     = (pixel_value >= C_THRESHOLD);
  assign w_push       = w_accept & w_active;
  assign w_pop        = ~w_queueEmpty & out_ready;
  assign w_lastPixel  = (r_pixelCount == C_LAST_PIXEL);
  // A new frame may only be launched from IDLE or DONE; pulses during a scan are dropped.
  assign w_startFrame = frame_start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and pixel-side ready; ready depends only on registered state.
  always_comb begin
    w_nextState  = r_state;
    w_pixelReady = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_nextState = S_SCAN;
        end
      end
      S_SCAN: begin
        w_pixelReady = (r_count < C_DEPTH);
        if (pixel_valid && w_pixelReady && w_lastPixel) begin
          w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_queueEmpty) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (frame_start) begin
          w_nextState = S_SCAN;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Per-frame counters and the done flags; a frame start wipes the previous frame's results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pixelCount  <= '0;
      r_activeCount <= '0;
      r_scanDone    <= 1'b0;
      r_frameDone   <= 1'b0;
    end else if (w_startFrame) begin
      r_pixelCount  <= '0;
      r_activeCount <= '0;
      r_scanDone    <= 1'b0;
      r_frameDone   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pixelCount <= r_pixelCount + INDEX_WIDTH'(1);
        if (w_lastPixel) begin
          r_scanDone <= 1'b1;
        end
      end
      if (w_push) begin
        r_activeCount <= r_activeCount + (INDEX_WIDTH + 1)'(1);
      end
      if ((r_state == S_DRAIN) && w_queueEmpty) begin
        r_frameDone <= 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy and the last popped index (shown while the queue is empty).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_lastIndex <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= f_nextPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr     <= f_nextPtr(r_rdPtr);
        r_lastIndex <= r_indexMem[r_rdPtr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage is not reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_indexMem[r_wrPtr] <= r_pixelCount;
    end
  end

`ifdef SPARSE_QUEUE_VALUE_OUT_EN
  logic [PIXEL_WIDTH-1:0] r_valueMem [QUEUE_DEPTH];
  logic [PIXEL_WIDTH-1:0] r_lastValue;

  // Value side-storage written alongside the index.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_valueMem[r_wrPtr] <= pixel_value;
    end
  end

  // Last popped value, held on the output while the queue is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastValue <= '0;
    end else if (w_pop) begin
      r_lastValue <= r_valueMem[r_rdPtr];
    end
  end

  assign out_value = w_queueEmpty ? r_lastValue : r_valueMem[r_rdPtr];
`endif

  // The head entry falls through directly; an empty queue holds the last delivered index.
  assign out_index    = w_queueEmpty ? r_lastIndex : r_indexMem[r_rdPtr];
  assign out_valid    = ~w_queueEmpty;
  assign pixel_ready  = w_pixelReady;
  assign queue_count  = r_count;
  assign active_count = r_activeCount;
  assign scan_done    = r_scanDone;
  assign frame_done   = r_frameDone;

endmodule
`default_nettype wire

// File: tb/tb_sparse_index_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sparse_index_queue                                        |
// | Description : Self-checking bench for sparse_index_queue. A queue-level    |
// |               reference model predicts every output each cycle; directed  |
// |               frames pin the model with hand-computed index sequences.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sparse_index_queue;

  localparam int NI = 784;
  localparam int IW = 10;
  localparam int QD = 4;
  localparam int PW = 8;
  localparam int TH = 128;
  localparam int CW = $clog2(QD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          pixel_valid = 1'b0;
  logic [PW-1:0] pixel_value = '0;
  logic          pixel_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_index;
`ifdef SPARSE_QUEUE_VALUE_OUT_EN
  logic [PW-1:0] out_value;
`endif
  logic [CW-1:0] queue_count;
  logic [IW:0]   active_count;
  logic          scan_done;
  logic          frame_done;

  sparse_index_queue #(
    .NUM_INPUTS (NI),
    .INDEX_WIDTH(IW),
    .QUEUE_DEPTH(QD),
    .PIXEL_WIDTH(PW),
    .THRESHOLD  (TH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .pixel_value (pixel_value),
    .pixel_ready (pixel_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
`ifdef SPARSE_QUEUE_VALUE_OUT_EN
    .out_value   (out_value),
`endif
    .queue_count (queue_count),
    .active_count(active_count),
    .scan_done   (scan_done),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queue level) ----------------
  // phase: 0 idle, 1 scanning, 2 draining, 3 done
  int mPhase = 0;
  int mQ[$];
  int mV[$];
  int mCnt = 0;
  int mAct = 0;
  bit mScanDone = 0;
  bit mFrameDone = 0;
  int mLastIdx = 0;
  int mLastVal = 0;
  int mPops[$];
  int mValPops[$];

  always @(posedge clk or negedge reset) begin
    int sz;
    bit doPop;
    bit doAcc;
    if (!reset) begin
      mPhase = 0; mQ.delete(); mV.delete(); mCnt = 0; mAct = 0;
      mScanDone = 0; mFrameDone = 0; mLastIdx = 0; mLastVal = 0;
    end else begin
      sz    = mQ.size();
      doPop = (sz != 0) && out_ready;
      doAcc = (mPhase == 1) && (sz < QD) && pixel_valid;
      if (doPop) begin
        mLastIdx = mQ.pop_front();
        mLastVal = mV.pop_front();
        mPops.push_back(mLastIdx);
        mValPops.push_back(mLastVal);
      end
      if ((mPhase == 0 || mPhase == 3) && frame_start) begin
        mPhase = 1; mCnt = 0; mAct = 0; mScanDone = 0; mFrameDone = 0;
      end else if (mPhase == 1 && doAcc) begin
        if (int'(pixel_value) >= TH) begin
          mQ.push_back(mCnt);
          mV.push_back(int'(pixel_value));
          mAct++;
        end
        if (mCnt == NI - 1) begin
          mPhase = 2;
          mScanDone = 1;
        end
        mCnt++;
      end else if (mPhase == 2 && sz == 0) begin
        mPhase = 3;
        mFrameDone = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit anyValid = 0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("pixel_ready", pixel_ready, (mPhase == 1) && (mQ.size() < QD));
      chk("out_valid", out_valid, mQ.size() != 0);
      chk("out_index", out_index, (mQ.size() != 0) ? mQ[0] : mLastIdx);
      chk("queue_count", queue_count, mQ.size());
      chk("active_count", active_count, mAct);
      chk("scan_done", scan_done, mScanDone);
      chk("frame_done", frame_done, mFrameDone);
`ifdef SPARSE_QUEUE_VALUE_OUT_EN
      chk("out_value", out_value, (mV.size() != 0) ? mV[0] : mLastVal);
`endif
      if (out_valid === 1'b1) anyValid = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [PW-1:0] pix [NI];
  int  scanIdx = 0;
  bit  abortScan = 0;

  task automatic clearPix();
    for (int i = 0; i < NI; i++) pix[i] = '0;
  endtask

  task automatic startFrame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  // Offers pixels in order; the index advances when ready is seen high (accept at next edge).
  task automatic scanPixels();
    int guard;
    guard = 0;
    scanIdx = 0;
    while (scanIdx < NI && !abortScan && guard < 20000) begin
      @(negedge clk);
      if (abortScan) break;
      pixel_valid = 1'b1;
      pixel_value = pix[scanIdx];
      if (pixel_ready === 1'b1) scanIdx++;
      guard++;
    end
    if (guard >= 20000) begin
      checks++; failures++;
      $display("FAIL scan_timeout: got idx %0d expected %0d", scanIdx, NI);
    end
  endtask

  task automatic endScan();
    @(negedge clk);
    pixel_valid = 1'b0;
    pixel_value = '0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_reached", frame_done, 1);
  endtask

  task automatic chkPops(input string nm, input int exp[$]);
    chk({nm, "_count"}, mPops.size(), exp.size());
    for (int i = 0; i < exp.size() && i < mPops.size(); i++)
      chk(nm, mPops[i], exp[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed frames ----------------
  initial begin
    int n;
    int exp[$];
    clearPix();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pixel_ready", pixel_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_queue_count", queue_count, 0);
    chk("rst_active_count", active_count, 0);
    chk("rst_scan_done", scan_done, 0);
    chk("rst_frame_done", frame_done, 0);
`ifdef SPARSE_QUEUE_VALUE_OUT_EN
    chk("rst_out_value", out_value, 0);
`endif
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_not_ready", pixel_ready, 0);

    // Frame 1: all pixels inactive.
    out_ready = 1'b1;
    mPops.delete(); anyValid = 0;
    startFrame();
    scanPixels();
    endScan();
    chk("f1_scan_done", scan_done, 1);
    chk("f1_frame_done_drain", frame_done, 0);
    @(negedge clk);
    chk("f1_frame_done_n1", frame_done, 1);
    @(negedge clk);
    chk("f1_frame_done_n2", frame_done, 1);
    chk("f1_active_count", active_count, 0);
    chk("f1_no_valid", anyValid, 0);
    chk("f1_pops", mPops.size(), 0);

    // Frame 2: pixels 0, 5, 783 active, consumer always ready.
    pix[0] = 8'd200; pix[5] = 8'd200; pix[783] = 8'd200;
    mPops.delete();
    startFrame();
    scanPixels();
    endScan();
    waitDone();
    exp = '{0, 5, 783};
    chkPops("f2_pop", exp);
    chk("f2_active_count", active_count, 3);
    chk("f2_model_active", mAct, 3);
    chk("f2_hold_index", out_index, 783);
    chk("f2_empty", out_valid, 0);

    // Frame 3: ten consecutive actives with a stalled consumer, then release.
    clearPix();
    for (int i = 0; i < 10; i++) pix[i] = 8'd255;
    out_ready = 1'b0;
    mPops.delete();
    startFrame();
    fork
      scanPixels();
      begin
        n = 0;
        while (!(pixel_ready === 1'b0 && queue_count == CW'(QD)) && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("f3_full_count", queue_count, QD);
        chk("f3_accepts_at_full", scanIdx, 4);
        repeat (3) begin
          @(negedge clk);
          chk("f3_stall_ready", pixel_ready, 0);
        end
        chk("f3_stall_accepts", scanIdx, 4);
        out_ready = 1'b1;
        chk("f3_full_pop_ready", pixel_ready, 0);
        @(negedge clk);
        chk("f3_ready_after_pop", pixel_ready, 1);
        chk("f3_count_after_pop", queue_count, 3);
      end
    join
    endScan();
    waitDone();
    exp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    chkPops("f3_pop", exp);
    chk("f3_active_count", active_count, 10);

    // Frame 4: threshold boundary at 128, plus a value-carrying entry at index 7.
    clearPix();
    pix[1] = 8'd127; pix[2] = 8'd128; pix[3] = 8'd255; pix[7] = 8'h9A;
    mPops.delete(); mValPops.delete();
    startFrame();
    scanPixels();
    endScan();
    waitDone();
    exp = '{2, 3, 7};
    chkPops("f4_pop", exp);
    chk("f4_active_count", active_count, 3);
    chk("f4_model_val7", (mValPops.size() == 3) ? mValPops[2] : -1, 8'h9A);
`ifdef SPARSE_QUEUE_VALUE_OUT_EN
    chk("f4_hold_value", out_value, 8'h9A);
`endif

    // Frame 5: reset in the middle of a scan with three entries queued.
    clearPix();
    pix[0] = 8'd255; pix[1] = 8'd255; pix[2] = 8'd255;
    out_ready = 1'b0;
    abortScan = 0;
    startFrame();
    fork
      scanPixels();
      begin
        n = 0;
        while (queue_count != CW'(3) && n < 200) begin
          @(negedge clk);
          n++;
        end
        #2;
        reset = 1'b0;
        abortScan = 1;
        #1;
        chk("f5_rst_out_valid", out_valid, 0);
        chk("f5_rst_queue_count", queue_count, 0);
        chk("f5_rst_pixel_ready", pixel_ready, 0);
        chk("f5_rst_active_count", active_count, 0);
      end
    join
    pixel_valid = 1'b0;
    abortScan = 0;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("f5_idle_after_reset", pixel_ready, 0);
    chk("f5_empty_after_reset", out_valid, 0);
    clearPix();
    pix[0] = 8'd255; pix[10] = 8'd255;
    out_ready = 1'b1;
    mPops.delete();
    startFrame();
    scanPixels();
    endScan();
    waitDone();
    exp = '{0, 10};
    chkPops("f5_pop", exp);
    chk("f5_active_count", active_count, 2);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
